// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display datapath: char width,
// digit count, blank code and scroll sequencer state encoding.
package disp_pkg;
  localparam int unsigned CHAR_W     = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  BLANK_CHAR = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_READY  = 2'd2,
    ST_SCROLL = 2'd3
  } state_t;
endpackage

// File: rtl/step_prescaler.sv
// Free-running step divider: while enabled, emits a one-cycle tick every
// STEP_DIV clocks; clr forces the count back to zero.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 4096
) (
  input  logic clk16,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(STEP_DIV - 1));

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/msg_scroll_ctrl.sv
// Scroll sequencer: buffers a message of char codes and slides a 4-char
// window across it at a fixed step rate, wrapping at the end of the message.
module msg_scroll_ctrl #(
  parameter int unsigned MSG_LEN  = 16,
  parameter int unsigned STEP_DIV = 4096,
  parameter int unsigned CHAR_W   = disp_pkg::CHAR_W
) (
  input  logic                clk16,
  input  logic                reset,
  input  logic                clear,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CHAR_W-1:0]   wr_data,
  input  logic                wr_last,
  input  logic                start,
  input  logic                stop,
  output logic [4*CHAR_W-1:0] win_chars,
  output logic                busy,
  output logic                wrap_pulse
);
  import disp_pkg::*;

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned PW = AW + 1;
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CHAR);
  localparam logic [NUM_DIGITS*CHAR_W-1:0] BLANK_WIN = {NUM_DIGITS{BLANK}};

  state_t              state;
  logic [CHAR_W-1:0]   msg_buf [MSG_LEN];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       msg_len;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       idx;
  logic [NUM_DIGITS*CHAR_W-1:0] win_next;
  logic                beat;
  logic                tick;
  logic                div_clr;

  assign wr_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign beat     = wr_valid && wr_ready;
  assign div_clr  = clear || stop || (state != ST_SCROLL);

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk16 (clk16),
    .reset (reset),
    .clr   (div_clr),
    .en    (state == ST_SCROLL),
    .tick  (tick)
  );

  // (pos+k) mod msg_len by repeated conditional subtract; up to three passes
  // cover messages shorter than the window.
  always_comb begin
    win_next = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = pos + PW'(k);
      for (int unsigned r = 0; r < NUM_DIGITS - 1; r++) begin
        if (idx >= msg_len) idx = idx - msg_len;
      end
      win_next[(NUM_DIGITS-1-k)*CHAR_W +: CHAR_W] = msg_buf[idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      msg_len    <= '0;
      pos        <= '0;
      win_chars  <= BLANK_WIN;
      busy       <= 1'b0;
      wrap_pulse <= 1'b0;
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_buf[i] <= BLANK;
    end else begin
      wrap_pulse <= 1'b0;
      if (clear) begin
        state     <= ST_IDLE;
        wr_ptr    <= '0;
        msg_len   <= '0;
        pos       <= '0;
        win_chars <= BLANK_WIN;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_LOAD: begin
            win_chars <= BLANK_WIN;
            if (beat) begin
              msg_buf[wr_ptr[AW-1:0]] <= wr_data;
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_last || (wr_ptr == PW'(MSG_LEN - 1))) begin
                msg_len <= wr_ptr + 1'b1;
                state   <= ST_READY;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
          ST_READY: begin
            win_chars <= win_next;
            if (!stop && start) begin
              state <= ST_SCROLL;
              busy  <= 1'b1;
            end
          end
          ST_SCROLL: begin
            win_chars <= win_next;
            if (stop) begin
              state <= ST_READY;
              busy  <= 1'b0;
            end else if (tick) begin
              if (pos == msg_len - 1'b1) begin
                pos        <= '0;
                wrap_pulse <= 1'b1;
              end else begin
                pos <= pos + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// Directed bench for msg_scroll_ctrl with a queue-based reference model
// checked every cycle plus literal window checks at key points.
module tb_msg_scroll_ctrl;
  localparam int MSG_LEN  = 16;
  localparam int STEP_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0, wr_valid = 1'b0, wr_last = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  wr_data = '0;
  logic        wr_ready, busy, wrap_pulse;
  logic [15:0] win_chars;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msg_scroll_ctrl #(.MSG_LEN(MSG_LEN), .STEP_DIV(STEP_DIV), .CHAR_W(4)) dut (
    .clk16(clk), .reset(rst), .clear(clear), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .start(start), .stop(stop),
    .win_chars(win_chars), .busy(busy), .wrap_pulse(wrap_pulse)
  );

  // Reference model: message as a queue, window by modulo indexing.
  logic [3:0]  m_msg [$];
  bit          m_done, m_run, m_wrap;
  int          m_pos, m_cnt;
  logic [15:0] m_win;

  function automatic logic [15:0] window(input int p);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[15-4*k -: 4] = m_msg[(p + k) % m_msg.size()];
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_msg.delete(); m_done = 0; m_run = 0; m_pos = 0; m_cnt = 0;
      m_win = 16'hFFFF; m_wrap = 0;
    end else begin
      m_win  = m_done ? window(m_pos) : 16'hFFFF;
      m_wrap = 0;
      if (clear) begin
        m_msg.delete(); m_done = 0; m_run = 0; m_pos = 0; m_cnt = 0; m_win = 16'hFFFF;
      end else if (!m_done) begin
        if (wr_valid) begin
          m_msg.push_back(wr_data);
          if (wr_last || m_msg.size() == MSG_LEN) m_done = 1;
        end
      end else if (stop) begin
        m_run = 0; m_cnt = 0;
      end else if (!m_run) begin
        if (start) begin m_run = 1; m_cnt = 0; end
      end else if (m_cnt == STEP_DIV - 1) begin
        m_cnt  = 0;
        m_pos  = (m_pos + 1) % m_msg.size();
        m_wrap = (m_pos == 0);
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("model_win",   win_chars, m_win);
    check("model_busy",  {15'd0, busy}, {15'd0, m_run});
    check("model_ready", {15'd0, wr_ready}, {15'd0, !m_done});
    check("model_wrap",  {15'd0, wrap_pulse}, {15'd0, m_wrap});
  end

  task automatic put(input logic [3:0] d, input logic l);
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_last = l;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    wr_valid = 0; wr_last = 0; start = 0; stop = 0; clear = 0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wraps;
    repeat (2) @(negedge clk);
    check("rst_win", win_chars, 16'hFFFF);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ready", {15'd0, wr_ready}, 16'd1);
    rst = 1'b0;

    // six-char message, scroll and wrap
    for (int i = 0; i < 6; i++) put(4'(i), i == 5);
    idle(2);
    check("load6_win", win_chars, 16'h0123);
    check("load6_ready", {15'd0, wr_ready}, 16'd0);
    pulse_start();
    repeat (5) @(negedge clk);
    check("step1_win", win_chars, 16'h1234);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wrap_pulse) wraps++;
    end
    check("wrap_count", 16'(wraps), 16'd1);
    check("wrap_win", win_chars, 16'h0123);

    // stop on the tick cycle, then resume
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    check("stop_win", win_chars, 16'h0123);
    pulse_start();
    check("resume_busy", {15'd0, busy}, 16'd1);
    repeat (5) @(negedge clk);
    check("resume_win", win_chars, 16'h1234);

    // reset mid-scroll
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_win", win_chars, 16'hFFFF);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_ready", {15'd0, wr_ready}, 16'd1);
    rst = 1'b0;

    // short messages repeat
    put(4'hA, 0); put(4'hB, 1); idle(2);
    check("ab_win", win_chars, 16'hABAB);
    pulse_start();
    repeat (5) @(negedge clk);
    check("ba_win", win_chars, 16'hBABA);
    pulse_clear();
    check("clr_win", win_chars, 16'hFFFF);
    put(4'h7, 1); idle(2);
    check("one_win", win_chars, 16'h7777);

    // clear+start with a beat in READY: beat dropped
    @(negedge clk);
    clear = 1; start = 1; wr_valid = 1; wr_data = 4'h9; wr_last = 1;
    idle(1);
    check("cs_win", win_chars, 16'hFFFF);
    check("cs_ready", {15'd0, wr_ready}, 16'd1);
    check("cs_busy", {15'd0, busy}, 16'd0);
    put(4'hC, 0); put(4'hD, 1); idle(2);
    check("cd_win", win_chars, 16'hCDCD);

    // full buffer without wr_last; extra beat ignored
    pulse_clear();
    for (int i = 0; i < 16; i++) put(4'(i), 1'b0);
    put(4'h9, 1'b1);
    idle(2);
    check("full_ready", {15'd0, wr_ready}, 16'd0);
    check("full_win", win_chars, 16'h0123);
    pulse_start();
    repeat (61) @(negedge clk);
    check("pos15_win", win_chars, 16'hF012);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
